// File: rtl/button_cond_pkg.sv
// button_cond_pkg: channel state encoding and default parameters for the button conditioner
// Shared by button_channel and button_conditioner; no ports.
package button_cond_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_t;
    localparam int DEF_N_CH          = 4;
    localparam int DEF_DB_CYCLES     = 500000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;
    localparam int DEF_ACTIVE_LOW    = 1;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: per-channel button inputs and conditioned outputs
// buttons_in/repeat_en flow master->slave; level_out, press_pulse, release_pulse flow slave->master.
interface button_conditioner_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] buttons_in;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    modport master (
        output buttons_in, repeat_en,
        input  level_out, press_pulse, release_pulse
    );
    modport slave (
        input  buttons_in, repeat_en,
        output level_out, press_pulse, release_pulse
    );
endinterface

// File: rtl/button_channel.sv
// button_channel: one button channel -- synchronizer, debounce and auto-repeat state machine
// i_clock/i_n_reset: clock and async active-low reset; i_button: raw level; i_repeat_en: auto-repeat enable
// o_level: debounced pressed level; o_press: press/repeat pulse; o_release: release pulse
module button_channel
    import button_cond_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
    input  logic i_clock,
    input  logic i_n_reset,
    input  logic i_button,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    localparam int   DB_W     = $clog2(DB_CYCLES);
    localparam int   RP_W     = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic IDLE_RAW = ACTIVE_LOW != 0;
    logic            r_sync1, r_sync2, r_level, r_press, r_release;
    logic [DB_W-1:0] r_db_cnt;
    logic [RP_W-1:0] r_rpt_cnt;
    state_t          r_state;
    logic            w_pressed, w_differs, w_accept;
    // XOR with the raw idle level normalises so that 1 always means pressed
    assign w_pressed = r_sync2 ^ IDLE_RAW;
    assign w_differs = w_pressed != r_level;
    assign w_accept  = w_differs && r_db_cnt == DB_W'(DB_CYCLES - 1);
    always_ff @(posedge i_clock or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_sync1  <= IDLE_RAW;
            r_sync2  <= IDLE_RAW;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else begin
            r_sync1  <= i_button;
            r_sync2  <= r_sync1;
            r_db_cnt <= (w_differs && !w_accept) ? r_db_cnt + 1'b1 : '0;
            r_level  <= r_level ^ w_accept;
        end
    end
    // An accepted edge overrides any repeat event in the same cycle, so press and release never coincide
    always_ff @(posedge i_clock or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_accept) begin
                r_state   <= w_pressed ? HELD : IDLE;
                r_rpt_cnt <= '0;
                r_press   <= w_pressed;
                r_release <= !w_pressed;
            end else begin
                case (r_state)
                    HELD: begin
                        if (!i_repeat_en) begin
                            r_rpt_cnt <= '0;
                        end else if (r_rpt_cnt == RP_W'(REPEAT_DELAY - 1)) begin
                            r_rpt_cnt <= '0;
                            r_press   <= 1'b1;
                            r_state   <= REPEAT;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!i_repeat_en) begin
                            r_rpt_cnt <= '0;
                            r_state   <= HELD;
                        end else if (r_rpt_cnt == RP_W'(REPEAT_PERIOD - 1)) begin
                            r_rpt_cnt <= '0;
                            r_press   <= 1'b1;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_rpt_cnt <= '0;
                    end
                endcase
            end
        end
    end
    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_CH independent debounced buttons with press/release pulses and auto-repeat
// clock: system clock; n_reset: async active-low reset; bus: slave side of button_conditioner_if
module button_conditioner
    import button_cond_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
    input logic                  clock,
    input logic                  n_reset,
    button_conditioner_if.slave  bus
);
    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_ch
            button_channel #(
                .DB_CYCLES    (DB_CYCLES),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_ch (
                .i_clock    (clock),
                .i_n_reset  (n_reset),
                .i_button   (bus.buttons_in[c]),
                .i_repeat_en(bus.repeat_en[c]),
                .o_level    (bus.level_out[c]),
                .o_press    (bus.press_pulse[c]),
                .o_release  (bus.release_pulse[c])
            );
        end
    endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus, per-cycle model comparison and literal timing checks
module tb_button_conditioner;
    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    logic clock = 1'b0;
    logic n_reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    button_conditioner_if #(.N_CH(N)) bus();
    button_conditioner #(
        .N_CH(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)
    ) dut (
        .clock  (clock),
        .n_reset(n_reset),
        .bus    (bus)
    );
    always #5 clock = ~clock;
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction
    // Model: a two-sample input delay, a stability run length, and elapsed-held-time arithmetic for repeats
    logic [N-1:0] m_d1 = '0, m_d2 = '0, m_lvl = '0, m_pp = '0, m_rp = '0;
    int m_run[N];
    int m_e[N];
    always @(posedge clock) begin
        cyc++;
        for (int c = 0; c < N; c++) begin
            m_pp[c] = 1'b0;
            m_rp[c] = 1'b0;
            if (!n_reset) begin
                m_d1[c] = 1'b0;
                m_d2[c] = 1'b0;
                m_lvl[c] = 1'b0;
                m_run[c] = 0;
                m_e[c] = 0;
            end else begin
                m_run[c] = (m_d2[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == DB) begin
                    m_lvl[c] = m_d2[c];
                    m_run[c] = 0;
                    m_e[c] = 0;
                    m_pp[c] = m_lvl[c];
                    m_rp[c] = !m_lvl[c];
                end else if (m_lvl[c]) begin
                    m_e[c] = bus.repeat_en[c] ? m_e[c] + 1 : 0;
                    m_pp[c] = m_e[c] == RD || (m_e[c] > RD && (m_e[c] - RD) % RP == 0);
                end
                m_d2[c] = m_d1[c];
                m_d1[c] = !bus.buttons_in[c];
            end
        end
        #1;
        check("model_level", 32'(bus.level_out), 32'(m_lvl));
        check("model_press", 32'(bus.press_pulse), 32'(m_pp));
        check("model_release", 32'(bus.release_pulse), 32'(m_rp));
        check("press_release_excl", 32'(bus.press_pulse & bus.release_pulse), 0);
    end
    initial begin
        logic seen;
        int q[$];
        int rel_at;
        int late;
        bus.buttons_in = '1;
        bus.repeat_en = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 32'({bus.level_out, bus.press_pulse, bus.release_pulse}), 0);
        #2 n_reset = 1'b1;
        repeat (3) @(posedge clock);
        #3 bus.buttons_in[0] = 1'b0;
        repeat (5) @(posedge clock);
        #1 check("press0_before", 32'({bus.level_out[0], bus.press_pulse[0]}), 0);
        @(posedge clock);
        #1 check("press0_at6", 32'({bus.level_out[0], bus.press_pulse[0]}), 32'b11);
        @(posedge clock);
        #1 check("press0_one_cycle", 32'(bus.press_pulse[0]), 0);
        #2 bus.buttons_in[0] = 1'b1;
        repeat (6) @(posedge clock);
        #1 check("release0_at6", 32'({bus.level_out[0], bus.release_pulse[0]}), 32'b01);
        #2 bus.buttons_in[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1 seen |= bus.level_out[1] | bus.press_pulse[1] | bus.release_pulse[1];
            #2;
        end
        bus.buttons_in[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1 seen |= bus.level_out[1] | bus.press_pulse[1] | bus.release_pulse[1];
            #2;
        end
        check("glitch3_ignored", 32'(seen), 0);
        bus.buttons_in[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1 seen |= bus.press_pulse[1];
            #2;
        end
        bus.buttons_in[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1 seen |= bus.press_pulse[1];
            #2;
        end
        check("pulse4_accepted", 32'(seen), 1);
        bus.repeat_en[2] = 1'b1;
        bus.buttons_in[2] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock);
            #1 if (bus.press_pulse[2]) q.push_back(i);
            #2;
        end
        check("repeat_count", q.size(), 6);
        if (q.size() >= 3) begin
            check("repeat_first", q[0], 6);
            check("repeat_gap_delay", q[1] - q[0], RD);
            check("repeat_gap_period", q[2] - q[1], RP);
        end
        bus.buttons_in[2] = 1'b1;
        rel_at = 0;
        late = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clock);
            #1 if (bus.release_pulse[2] && rel_at == 0) rel_at = i;
            if (rel_at != 0 && bus.press_pulse[2]) late++;
            #2;
        end
        check("release2_at6", rel_at, 6);
        check("repeat_stopped", late, 0);
        bus.buttons_in[0] = 1'b0;
        bus.buttons_in[3] = 1'b0;
        repeat (6) @(posedge clock);
        #1 check("simultaneous_press", 32'(bus.press_pulse & 4'b1001), 32'b1001);
        #2 bus.buttons_in[2] = 1'b0;
        repeat (20) @(posedge clock);
        #3 n_reset = 1'b0;
        #1 check("reset_immediate", 32'({bus.level_out, bus.press_pulse, bus.release_pulse}), 0);
        repeat (2) @(posedge clock);
        #3 n_reset = 1'b1;
        repeat (5) @(posedge clock);
        #1 check("repress_before", 32'(bus.press_pulse[2]), 0);
        @(posedge clock);
        #1 check("repress_at6", 32'(bus.press_pulse[2]), 1);
        #2 bus.buttons_in = '1;
        bus.repeat_en = '0;
        repeat (10) @(posedge clock);
        #1 check("final_idle", 32'(bus.level_out), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, legal range 1..16.
REQ-002 Parameter DB_CYCLES, default 500000: consecutive clock cycles a changed level must persist before it is accepted, minimum 2.
REQ-003 Parameter REPEAT_DELAY, default 25000000: cycles a button must be held before the first auto-repeat pulse, minimum 2.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between later auto-repeat pulses, minimum 2.
REQ-005 Parameter ACTIVE_LOW, default 1: 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".
REQ-006 clock  input  1  single system clock; all logic is rising-edge.
REQ-007 n_reset  input  1  asynchronous, active-low reset.
REQ-008 buttons_in  input  N_CH  raw asynchronous button levels.
REQ-009 repeat_en  input  N_CH  per-channel auto-repeat enable; treated as a synchronous, quasi-static input.
REQ-010 level_out  output  N_CH  debounced level per channel; 1 means pressed.
REQ-011 press_pulse  output  N_CH  one-cycle pulse on an accepted press and on each auto-repeat.
REQ-012 release_pulse  output  N_CH  one-cycle pulse on an accepted release.

Function
REQ-013 Each channel shall pass its input through a 2-flop synchronizer; the result is then normalised by ACTIVE_LOW so that 1 means pressed.
REQ-014 The debounce counter shall clear in every cycle where the synced value equals level_out, and increment when it differs.
REQ-015 When the counter reaches DB_CYCLES-1 while the values still differ, level_out shall toggle on the next edge and the counter shall clear.
REQ-016 A glitch shorter than DB_CYCLES cycles shall produce no output change.
REQ-017 Latency from a clean input edge to the level_out change shall be exactly DB_CYCLES+2 cycles.
REQ-018 press_pulse shall be high for exactly one cycle, in the same cycle level_out first reads 1.
REQ-019 release_pulse shall be high for exactly one cycle, in the same cycle level_out first reads 0.
REQ-020 Each channel shall run a state machine with states IDLE, HELD and REPEAT.
REQ-021 State transitions:
- IDLE -> HELD on an accepted press; the repeat counter loads 0.
- In HELD, when repeat_en=1 and the counter reaches REPEAT_DELAY-1: pulse press_pulse, clear the counter, go to REPEAT.
- In REPEAT, when the counter reaches REPEAT_PERIOD-1: pulse press_pulse and clear the counter.
- Any state -> IDLE on an accepted release; the repeat counter clears.
REQ-022 If repeat_en drops while in HELD or REPEAT, the state machine shall go to HELD with the counter cleared and generate no further repeat pulses.
REQ-023 The repeat counter shall stay frozen at 0 in HELD while repeat_en=0.
REQ-024 Counter widths shall be $clog2 of the relevant parameter; no counter shall wrap past its terminal value.
REQ-025 Channels shall be fully independent; simultaneous events on several channels shall each produce their own pulses in the same cycle.
REQ-026 press_pulse and release_pulse for one channel shall never be high in the same cycle.

Reset
REQ-027 While n_reset=0, all synchronizer flops shall hold the not-pressed level, all counters shall be 0, all state machines shall be in IDLE, and level_out, press_pulse and release_pulse shall all be 0.
REQ-028 Reset asserted mid-debounce or mid-repeat shall abort the operation without emitting any pulse.
REQ-029 After deassertion, a button already held shall be accepted as a new press after DB_CYCLES+2 cycles.

Structure
REQ-030 Package button_cond_pkg shall hold the state encoding (IDLE=2'd0, HELD=2'd1, REPEAT=2'd2) and the default parameter constants.
REQ-031 One sub-module, button_channel, shall implement one channel (synchronizer, debounce, state machine); the top shall instantiate it N_CH times with a generate loop.

Verification (N_CH=4, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1)
REQ-032 Clean press: buttons_in[0] driven 1->0 and held -> level_out[0]=1 and press_pulse[0] one cycle, both exactly 6 cycles later.
REQ-033 Glitch: buttons_in[1] low for 3 cycles, then high -> no change on any output.
REQ-034 Auto-repeat: repeat_en[2]=1, press held for 30 cycles -> initial pulse, then a pulse 10 cycles later, then pulses every 3 cycles; on release, release_pulse[2] fires 6 cycles after the input edge and repeats stop.
REQ-035 Simultaneous events: channels 0 and 3 pressed on the same edge -> both press_pulse bits high in the same cycle.
REQ-036 Reset mid-repeat: n_reset pulsed low while channel 2 is in REPEAT with the button still held -> all outputs 0 at once; after deassertion, a new press_pulse[2] arrives 6 cycles later.
